// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC controller: opcodes, ALU classes,
// FSM states, trap causes and the per-state control word.
package risc_ctrl_pkg;

    localparam logic [3:0] OP_LW   = 4'h0;
    localparam logic [3:0] OP_SW   = 4'h1;
    localparam logic [3:0] OP_R_LO = 4'h2;
    localparam logic [3:0] OP_R_HI = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_J    = 4'hD;

    localparam logic [1:0] ALU_OP_FUNC = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_ADD  = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EX_R, S_WB_R, S_EX_ADDR,
        S_MEM, S_WB_M, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef struct packed {
        logic is_mem;
        logic is_load;
        logic is_r;
        logic is_br;
        logic is_bne;
        logic is_j;
        logic illegal;
    } op_class_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       trap;
    } ctrl_t;

    // Moore part of the control word; FETCH's ack-gated strobes are added at the top.
    function automatic ctrl_t state_ctrl(input state_t s, input logic is_load, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   c.imem_req = 1'b1;
            S_EX_R:    c.reg_dst  = 1'b1;
            S_WB_R:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_EX_ADDR: begin c.alu_src = 1'b1; c.alu_op = ALU_OP_ADD; end
            S_MEM: begin
                c.dmem_req  = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_OP_ADD;
                c.mem_read  = is_load;
                c.mem_write = !is_load;
            end
            S_WB_M:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_BRANCH: begin
                c.alu_op = ALU_OP_SUB;
                c.beq    = !is_bne;
                c.bne    = is_bne;
            end
            S_JUMP:    begin c.jump = 1'b1; c.pc_write = 1'b1; end
            S_TRAP:    c.trap = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_class_decoder.sv
// Combinational opcode classifier feeding the DECODE dispatch.
// Any opcode outside LW/SW/R/BEQ/BNE/J, including values above 4 bits, is illegal.
import risc_ctrl_pkg::*;

module opcode_class_decoder #(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           cls
);

    logic [3:0] op_lo;
    logic       op_hi;

    always_comb begin
        op_lo = opcode[3:0];
        op_hi = (OPCODE_W > 4) ? |(opcode >> 4) : 1'b0;
        cls   = '0;
        if (op_hi) begin
            cls.illegal = 1'b1;
        end else begin
            case (op_lo)
                OP_LW:  begin cls.is_mem = 1'b1; cls.is_load = 1'b1; end
                OP_SW:  cls.is_mem = 1'b1;
                OP_BEQ: cls.is_br  = 1'b1;
                OP_BNE: begin cls.is_br = 1'b1; cls.is_bne = 1'b1; end
                OP_J:   cls.is_j   = 1'b1;
                default: begin
                    if (op_lo >= OP_R_LO && op_lo <= OP_R_HI) cls.is_r    = 1'b1;
                    else                                      cls.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXECUTE/MEM/WB sequencer for the 16-bit RISC datapath with an
// ack-timeout watchdog and illegal-opcode trap; control word registered with the state.
import risc_ctrl_pkg::*;

module multicycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2,
    parameter int TIMEOUT  = 15,
    parameter int TRAP_EN  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    input  logic                trap_clr,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                ir_load,
    output logic                pc_write,
    output logic                beq,
    output logic                bne,
    output logic                jump,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic       load_q, load_d;
    logic       bne_q, bne_d;
    op_class_t  cls;

    opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode (opcode),
        .cls    (cls)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        cause_d = cause_q;
        load_d  = load_q;
        bne_d   = bne_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                // Class flags are latched here so later opcode changes are harmless.
                load_d = cls.is_load;
                bne_d  = cls.is_bne;
                if (cls.illegal) begin
                    if (TRAP_EN != 0) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = S_EX_R;
                    end
                end else if (cls.is_mem) state_d = S_EX_ADDR;
                else if (cls.is_br)      state_d = S_BRANCH;
                else if (cls.is_j)       state_d = S_JUMP;
                else if (cls.is_r)       state_d = S_EX_R;
                else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EX_R:    state_d = S_WB_R;
            S_WB_R:    state_d = S_FETCH;
            S_EX_ADDR: state_d = S_MEM;
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = load_q ? S_WB_M : S_FETCH;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB_M, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP: begin
                if (trap_clr) begin
                    state_d = S_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            cnt_q   <= 8'd0;
            cause_q <= CAUSE_NONE;
            load_q  <= 1'b0;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, load_d, bne_d);
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            load_q  <= load_d;
            bne_q   <= bne_d;
        end
    end

    // ctrl_q.imem_req is high exactly in FETCH, so it gates the ack-driven strobes.
    assign ir_load    = ctrl_q.imem_req & imem_ack;
    assign pc_write   = ctrl_q.pc_write | ir_load;
    assign imem_req   = ctrl_q.imem_req;
    assign dmem_req   = ctrl_q.dmem_req;
    assign beq        = ctrl_q.beq;
    assign bne        = ctrl_q.bne;
    assign jump       = ctrl_q.jump;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);
    assign trap       = ctrl_q.trap;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus
// hand-written timeout, trap-disable and mid-operation reset sequences.
module tb_multicycle_control_unit;

    localparam logic [17:0] IREQ = 18'h20000, DREQ = 18'h10000, IRL  = 18'h08000,
                            PCW  = 18'h04000, BEQ  = 18'h02000, BNE  = 18'h01000,
                            JMP  = 18'h00800, MRD  = 18'h00400, MWR  = 18'h00200,
                            ASRC = 18'h00100, RDST = 18'h00080, M2R  = 18'h00040,
                            RWR  = 18'h00020, AADD = 18'h00010, ASUB = 18'h00008,
                            TRP  = 18'h00004, C_ILL = 18'h1, C_IM = 18'h2, C_DM = 18'h3;
    localparam logic [17:0] FA  = IREQ | IRL | PCW;
    localparam logic [17:0] LWM = DREQ | ASRC | AADD | MRD;
    localparam logic [17:0] SWM = DREQ | ASRC | AADD | MWR;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       imem_ack, dmem_ack, trap_clr;

    logic imem_req, dmem_req, ir_load, pc_write, beq, bne, jump, mem_read, mem_write;
    logic alu_src, reg_dst, mem_to_reg, reg_write, trap;
    logic [1:0] alu_op, trap_cause;

    logic imem_req_n, dmem_req_n, ir_load_n, pc_write_n, beq_n, bne_n, jump_n, mem_read_n;
    logic mem_write_n, alu_src_n, reg_dst_n, mem_to_reg_n, reg_write_n, trap_n;
    logic [1:0] alu_op_n, trap_cause_n;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(2), .TIMEOUT(TMO), .TRAP_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .trap_clr(trap_clr), .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load),
        .pc_write(pc_write), .beq(beq), .bne(bne), .jump(jump), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(2), .TIMEOUT(TMO), .TRAP_EN(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .trap_clr(trap_clr), .imem_req(imem_req_n), .dmem_req(dmem_req_n), .ir_load(ir_load_n),
        .pc_write(pc_write_n), .beq(beq_n), .bne(bne_n), .jump(jump_n), .mem_read(mem_read_n),
        .mem_write(mem_write_n), .alu_src(alu_src_n), .reg_dst(reg_dst_n),
        .mem_to_reg(mem_to_reg_n), .reg_write(reg_write_n), .alu_op(alu_op_n), .trap(trap_n),
        .trap_cause(trap_cause_n)
    );

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       ia;
        logic       da;
        logic       tc;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [17:0] obs_a();
        return {imem_req, dmem_req, ir_load, pc_write, beq, bne, jump, mem_read, mem_write,
                alu_src, reg_dst, mem_to_reg, reg_write, alu_op, trap, trap_cause};
    endfunction

    function automatic logic [17:0] obs_n();
        return {imem_req_n, dmem_req_n, ir_load_n, pc_write_n, beq_n, bne_n, jump_n, mem_read_n,
                mem_write_n, alu_src_n, reg_dst_n, mem_to_reg_n, reg_write_n, alu_op_n, trap_n,
                trap_cause_n};
    endfunction

    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic [3:0] op, input logic ia, input logic da,
                       input logic tc, input logic [17:0] exp);
        vec_t v;
        v.name = nm; v.op = op; v.ia = ia; v.da = da; v.tc = tc; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc(input string nm, input logic [17:0] exp);
        @(negedge clk);
        check(nm, obs_a(), exp);
        n_total++;
        if (!(mem_read && mem_write)) n_pass++;
        else $display("FAIL %s_rd_wr_excl: mem_read=1 mem_write=1, at most one allowed", nm);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input string nm, input logic [17:0] exp_a, input logic [17:0] exp_n);
        @(negedge clk);
        check(nm, obs_a(), exp_a);
        check({nm, "_noTrapEn"}, obs_n(), exp_n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; opcode = 4'h0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 4'h0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs_a(), 18'h0);
        rst_n = 1'b1;

        // R-type, zero wait
        add("r_idle",    4'h2, 1, 0, 0, 18'h0);
        add("r_fetch",   4'h2, 1, 0, 0, FA);
        add("r_decode",  4'h2, 1, 0, 0, 18'h0);
        add("r_ex",      4'h2, 1, 0, 0, RDST);
        add("r_wb",      4'h2, 1, 0, 0, RWR | RDST);
        // LW with dmem_ack three cycles late; opcode wiggles after DECODE
        add("lw_fetch",  4'h0, 1, 0, 0, FA);
        add("lw_decode", 4'h0, 1, 0, 0, 18'h0);
        add("lw_exaddr", 4'h5, 1, 0, 0, ASRC | AADD);
        add("lw_mem0",   4'h5, 1, 0, 0, LWM);
        add("lw_mem1",   4'h5, 1, 0, 0, LWM);
        add("lw_mem2",   4'h5, 1, 0, 0, LWM);
        add("lw_mem3",   4'h5, 1, 1, 0, LWM);
        add("lw_wbm",    4'h5, 1, 0, 0, RWR | M2R);
        // SW
        add("sw_fetch",  4'h1, 1, 0, 0, FA);
        add("sw_decode", 4'h1, 1, 0, 0, 18'h0);
        add("sw_exaddr", 4'h0, 1, 0, 0, ASRC | AADD);
        add("sw_mem",    4'h0, 1, 1, 0, SWM);
        // BEQ, BNE, J
        add("beq_fetch", 4'hB, 1, 0, 0, FA);
        add("beq_dec",   4'hB, 1, 0, 0, 18'h0);
        add("beq_br",    4'hB, 1, 0, 0, ASUB | BEQ);
        add("bne_fetch", 4'hC, 1, 0, 0, FA);
        add("bne_dec",   4'hC, 1, 0, 0, 18'h0);
        add("bne_br",    4'hC, 1, 0, 0, ASUB | BNE);
        add("j_fetch",   4'hD, 1, 0, 0, FA);
        add("j_dec",     4'hD, 1, 0, 0, 18'h0);
        add("j_jump",    4'hD, 1, 0, 0, JMP | PCW);
        // Illegal opcode trap and recovery
        add("ill_fetch", 4'hE, 1, 0, 0, FA);
        add("ill_dec",   4'hE, 1, 0, 0, 18'h0);
        add("trap0",     4'hE, 1, 0, 0, TRP | C_ILL);
        add("trap1",     4'hE, 1, 1, 0, TRP | C_ILL);
        add("trap_clr",  4'hE, 1, 0, 1, TRP | C_ILL);
        add("clr_fetch", 4'h3, 0, 0, 1, IREQ);
        add("re_fetch",  4'h3, 1, 0, 0, FA);
        add("re_decode", 4'h3, 1, 0, 0, 18'h0);
        add("re_ex",     4'h3, 1, 0, 0, RDST);
        add("re_wb",     4'h3, 1, 0, 0, RWR | RDST);
        add("re_fetch2", 4'h3, 1, 0, 0, FA);

        foreach (tbl[i]) begin
            opcode = tbl[i].op; imem_ack = tbl[i].ia; dmem_ack = tbl[i].da; trap_clr = tbl[i].tc;
            cyc(tbl[i].name, tbl[i].exp);
        end

        // imem never acks: TIMEOUT+1 FETCH cycles, then trap with cause 10
        do_reset();
        cyc("to_idle", 18'h0);
        for (int k = 0; k <= TMO; k++) cyc("to_fetch_wait", IREQ);
        cyc("imem_timeout", TRP | C_IM);
        trap_clr = 1'b1;
        cyc("imem_trap_clr", TRP | C_IM);
        trap_clr = 1'b0;
        cyc("imem_after_clr", IREQ);

        // ack arriving exactly at count==TIMEOUT wins
        do_reset();
        cyc("late_idle", 18'h0);
        for (int k = 0; k < TMO; k++) cyc("late_fetch_wait", IREQ);
        imem_ack = 1'b1;
        cyc("ack_at_limit", FA);
        imem_ack = 1'b0;
        cyc("ack_at_limit_decode", 18'h0);

        // dmem never acks during a load
        do_reset();
        imem_ack = 1'b1;
        cyc("dto_idle", 18'h0);
        cyc("dto_fetch", FA);
        imem_ack = 1'b0;
        cyc("dto_decode", 18'h0);
        cyc("dto_exaddr", ASRC | AADD);
        for (int k = 0; k <= TMO; k++) cyc("dto_mem_wait", LWM);
        cyc("dmem_timeout", TRP | C_DM);

        // opcode 0xE: trap with TRAP_EN=1, R-type with TRAP_EN=0
        do_reset();
        opcode = 4'hE; imem_ack = 1'b1;
        cyc2("te_idle", 18'h0, 18'h0);
        cyc2("te_fetch", FA, FA);
        cyc2("te_decode", 18'h0, 18'h0);
        cyc2("te_exec", TRP | C_ILL, RDST);
        cyc2("te_wb", TRP | C_ILL, RWR | RDST);

        // reset asserted in the middle of MEM
        do_reset();
        opcode = 4'h0; imem_ack = 1'b1;
        cyc("mr_idle", 18'h0);
        cyc("mr_fetch", FA);
        imem_ack = 1'b0;
        cyc("mr_decode", 18'h0);
        cyc("mr_exaddr", ASRC | AADD);
        cyc("mr_mem", LWM);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_mem", obs_a(), 18'h0);
        @(posedge clk);
        #1;
        check("rst_held", obs_a(), 18'h0);
        dmem_ack = 1'b0;
        rst_n = 1'b1;
        cyc("post_rst_idle", 18'h0);
        cyc("post_rst_fetch", FA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
